// File: rtl/sc_ir_pkg.sv
// Shared field positions, op-field constants and decoded-field bundle for
// the SPARC-format instruction register and its shadow copies.
package sc_ir_pkg;

    localparam int RD_MSB     = 29;
    localparam int RD_LSB     = 25;
    localparam int RS1_MSB    = 18;
    localparam int RS1_LSB    = 14;
    localparam int RS2_MSB    = 4;
    localparam int RS2_LSB    = 0;
    localparam int OP_MSB     = 31;
    localparam int OP_LSB     = 30;
    localparam int OP3_MSB    = 24;
    localparam int OP3_LSB    = 19;
    localparam int I_BIT      = 13;
    localparam int COND_MSB   = 28;
    localparam int COND_LSB   = 25;
    localparam int SIMM13_MSB = 12;
    localparam int DISP22_MSB = 21;
    localparam int DISP30_MSB = 29;

    localparam logic [1:0] OP_BRANCH = 2'b00;
    localparam logic [1:0] OP_CALL   = 2'b01;
    localparam logic [1:0] OP_ARITH  = 2'b10;
    localparam logic [1:0] OP_MEM    = 2'b11;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [7:0]  op;
        logic        ir13;
        logic [3:0]  cond;
        logic [31:0] simm13;
        logic [31:0] disp22;
        logic [31:0] disp30;
    } irFields_t;

endpackage

// File: rtl/sc_ir_field_decode.sv
// Combinational IR field slicer and sign-extender; shared by the main IR and
// the trap-handler shadow IR.
module sc_ir_field_decode
    import sc_ir_pkg::*;
(
    input  logic [31:0] ir,
    output irFields_t   fields
);

    always_comb begin
        fields        = '0;
        fields.rd     = ir[RD_MSB:RD_LSB];
        fields.rs1    = ir[RS1_MSB:RS1_LSB];
        fields.rs2    = ir[RS2_MSB:RS2_LSB];
        fields.op     = {ir[OP_MSB:OP_LSB], ir[OP3_MSB:OP3_LSB]};
        fields.ir13   = ir[I_BIT];
        fields.cond   = ir[COND_MSB:COND_LSB];
        fields.simm13 = {{(31-SIMM13_MSB){ir[SIMM13_MSB]}}, ir[SIMM13_MSB:0]};
        fields.disp22 = {{(31-DISP22_MSB){ir[DISP22_MSB]}}, ir[DISP22_MSB:0]};
        fields.disp30 = {{(31-DISP30_MSB){ir[DISP30_MSB]}}, ir[DISP30_MSB:0]};
    end

endmodule

// File: rtl/sc_reg_ir_queue.sv
// Instruction register fed by a DEPTH-entry prefetch FIFO, with empty-queue
// bypass and a flush that can capture a branch-target fetch.
module sc_reg_ir_queue
    import sc_ir_pkg::*;
#(
    parameter int DATAWIDTH_BUS           = 32,
    parameter int DEPTH                   = 4,
    parameter int DATAWIDTH_BUS_REG_IR    = 5,
    parameter int DATAWIDTH_BUS_REG_IR_OP = 8
) (
    input  logic                               SC_RegGENERAL_CLOCK_50,
    input  logic                               SC_RegGENERAL_RESET_InHigh,
    input  logic                               SC_RegGENERAL_Push_InLow,
    input  logic [DATAWIDTH_BUS-1:0]           SC_RegGENERAL_DataBUS_In,
    input  logic                               SC_RegGENERAL_Load_InLow,
    input  logic                               SC_RegGENERAL_Flush_InHigh,
    output logic [DATAWIDTH_BUS-1:0]           SC_RegGENERAL_DataBUS_Out,
    output logic                               SC_RegGENERAL_Valid,
    output logic [DATAWIDTH_BUS_REG_IR-1:0]    SC_RegGENERAL_RS1,
    output logic [DATAWIDTH_BUS_REG_IR-1:0]    SC_RegGENERAL_RS2,
    output logic [DATAWIDTH_BUS_REG_IR-1:0]    SC_RegGENERAL_RD,
    output logic [DATAWIDTH_BUS_REG_IR_OP-1:0] SC_RegGENERAL_OP,
    output logic                               SC_RegGENERAL_IR13,
    output logic [3:0]                         SC_RegGENERAL_Cond,
    output logic [DATAWIDTH_BUS-1:0]           SC_RegGENERAL_Simm13,
    output logic [DATAWIDTH_BUS-1:0]           SC_RegGENERAL_Disp22,
    output logic [DATAWIDTH_BUS-1:0]           SC_RegGENERAL_Disp30,
    output logic [$clog2(DEPTH):0]             SC_RegGENERAL_Count,
    output logic                               SC_RegGENERAL_Full,
    output logic                               SC_RegGENERAL_Empty,
    output logic                               SC_RegGENERAL_Overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][DATAWIDTH_BUS-1:0] queueMem;
    logic [PW-1:0]                       rdPtr, wrPtr;
    logic [CW-1:0]                       count;
    logic [DATAWIDTH_BUS-1:0]            irReg;
    logic                                validReg, overflowReg;

    logic pushEn, loadEn, flushEn, isFull, isEmpty;
    logic doPop, doBypass, doPush, memWe;
    logic [PW-1:0] memAddr;

    assign pushEn  = ~SC_RegGENERAL_Push_InLow;
    assign loadEn  = ~SC_RegGENERAL_Load_InLow;
    assign flushEn = SC_RegGENERAL_Flush_InHigh;
    assign isFull  = (count == CW'(DEPTH));
    assign isEmpty = (count == '0);

    // Flush outranks load; a full queue still accepts a push when a pop frees a slot.
    always_comb begin
        doPop    = ~flushEn & loadEn & ~isEmpty;
        doBypass = ~flushEn & loadEn & isEmpty & pushEn;
        doPush   = ~flushEn & pushEn & ~doBypass & (~isFull | doPop);
        memWe    = doPush | (flushEn & pushEn);
        memAddr  = flushEn ? '0 : wrPtr;
    end

    always_ff @(negedge SC_RegGENERAL_CLOCK_50) begin
        if (memWe) queueMem[memAddr] <= SC_RegGENERAL_DataBUS_In;
    end

    always_ff @(negedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
        if (SC_RegGENERAL_RESET_InHigh) begin
            rdPtr       <= '0;
            wrPtr       <= '0;
            count       <= '0;
            irReg       <= '0;
            validReg    <= 1'b0;
            overflowReg <= 1'b0;
        end else if (flushEn) begin
            rdPtr <= '0;
            wrPtr <= pushEn ? PW'(1) : '0;
            count <= pushEn ? CW'(1) : '0;
        end else begin
            if (loadEn) begin
                if (doPop) begin
                    irReg    <= queueMem[rdPtr];
                    validReg <= 1'b1;
                end else if (doBypass) begin
                    irReg    <= SC_RegGENERAL_DataBUS_In;
                    validReg <= 1'b1;
                end else begin
                    validReg <= 1'b0;
                end
            end
            if (doPush) wrPtr <= wrPtr + PW'(1);
            if (doPop)  rdPtr <= rdPtr + PW'(1);
            count <= count + CW'(doPush) - CW'(doPop);
            if (pushEn && isFull && !loadEn) overflowReg <= 1'b1;
        end
    end

    irFields_t fields;

    sc_ir_field_decode uDecode (
        .ir     (irReg),
        .fields (fields)
    );

    assign SC_RegGENERAL_DataBUS_Out = irReg;
    assign SC_RegGENERAL_Valid       = validReg;
    assign SC_RegGENERAL_RS1         = fields.rs1;
    assign SC_RegGENERAL_RS2         = fields.rs2;
    assign SC_RegGENERAL_RD          = fields.rd;
    assign SC_RegGENERAL_OP          = fields.op;
    assign SC_RegGENERAL_IR13        = fields.ir13;
    assign SC_RegGENERAL_Cond        = fields.cond;
    assign SC_RegGENERAL_Simm13      = fields.simm13;
    assign SC_RegGENERAL_Disp22      = fields.disp22;
    assign SC_RegGENERAL_Disp30      = fields.disp30;
    assign SC_RegGENERAL_Count       = count;
    assign SC_RegGENERAL_Full        = isFull;
    assign SC_RegGENERAL_Empty       = isEmpty;
    assign SC_RegGENERAL_Overflow    = overflowReg;

endmodule

// File: tb/tb_sc_reg_ir_queue.sv
// Directed bench for sc_reg_ir_queue: decode, bypass, overflow, flush and
// asynchronous reset, against hand-computed expected values.
module tb_sc_reg_ir_queue;

    logic        clk = 1'b1;
    logic        rst;
    logic        pushN, loadN, flush;
    logic [31:0] dIn;
    logic [31:0] dOut, simm13, disp22, disp30;
    logic        valid, ir13, full, empty, overflow;
    logic [4:0]  rs1, rs2, rd;
    logic [7:0]  op;
    logic [3:0]  cond;
    logic [2:0]  count;

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    sc_reg_ir_queue dut (
        .SC_RegGENERAL_CLOCK_50     (clk),
        .SC_RegGENERAL_RESET_InHigh (rst),
        .SC_RegGENERAL_Push_InLow   (pushN),
        .SC_RegGENERAL_DataBUS_In   (dIn),
        .SC_RegGENERAL_Load_InLow   (loadN),
        .SC_RegGENERAL_Flush_InHigh (flush),
        .SC_RegGENERAL_DataBUS_Out  (dOut),
        .SC_RegGENERAL_Valid        (valid),
        .SC_RegGENERAL_RS1          (rs1),
        .SC_RegGENERAL_RS2          (rs2),
        .SC_RegGENERAL_RD           (rd),
        .SC_RegGENERAL_OP           (op),
        .SC_RegGENERAL_IR13         (ir13),
        .SC_RegGENERAL_Cond         (cond),
        .SC_RegGENERAL_Simm13       (simm13),
        .SC_RegGENERAL_Disp22       (disp22),
        .SC_RegGENERAL_Disp30       (disp30),
        .SC_RegGENERAL_Count        (count),
        .SC_RegGENERAL_Full         (full),
        .SC_RegGENERAL_Empty        (empty),
        .SC_RegGENERAL_Overflow     (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one cycle's controls in the high phase, sample 1ns after the falling edge.
    task automatic cyc(input logic p, input logic l, input logic f, input logic [31:0] d);
        @(posedge clk);
        pushN = ~p; loadN = ~l; flush = f; dIn = d;
        @(negedge clk);
        #1;
        pushN = 1'b1; loadN = 1'b1; flush = 1'b0; dIn = '0;
    endtask

    task automatic chkReset(input string pfx);
        chk({pfx, "_ir"},       dOut,     32'h0);
        chk({pfx, "_valid"},    valid,    32'h0);
        chk({pfx, "_rd"},       rd,       32'h0);
        chk({pfx, "_simm13"},   simm13,   32'h0);
        chk({pfx, "_count"},    count,    32'h0);
        chk({pfx, "_empty"},    empty,    32'h1);
        chk({pfx, "_full"},     full,     32'h0);
        chk({pfx, "_overflow"}, overflow, 32'h0);
    endtask

    logic [31:0] words [0:4] = '{32'h11111111, 32'h22222222, 32'h33333333,
                                 32'h44444444, 32'h55555555};

    initial begin
        rst = 1'b1; pushN = 1'b1; loadN = 1'b1; flush = 1'b0; dIn = '0;
        #12;
        chkReset("rst");
        @(posedge clk); #2 rst = 1'b0;

        // Push then load, field decode
        cyc(1, 0, 0, 32'h8A004002);
        chk("push_count", count, 32'd1);
        chk("push_empty", empty, 32'h0);
        cyc(0, 1, 0, '0);
        chk("ld_ir",    dOut,  32'h8A004002);
        chk("ld_rd",    rd,    32'd5);
        chk("ld_rs1",   rs1,   32'd1);
        chk("ld_rs2",   rs2,   32'd2);
        chk("ld_ir13",  ir13,  32'h0);
        chk("ld_op",    op,    32'h80);
        chk("ld_valid", valid, 32'h1);
        chk("ld_empty", empty, 32'h1);

        // Bypass loads from empty queue
        cyc(1, 1, 0, 32'h84007FFF);
        chk("byp_ir13",  ir13,   32'h1);
        chk("byp_rd",    rd,     32'd2);
        chk("byp_rs1",   rs1,    32'd1);
        chk("byp_simm",  simm13, 32'hFFFFFFFF);
        chk("byp_count", count,  32'd0);
        chk("byp_valid", valid,  32'h1);
        cyc(1, 1, 0, 32'h10BFFFFF);
        chk("br_cond",   cond,   32'h8);
        chk("br_disp22", disp22, 32'hFFFFFFFF);
        cyc(1, 1, 0, 32'h40000010);
        chk("call_op",     op[7:6], 32'h1);
        chk("call_disp30", disp30,  32'h00000010);

        // Load from empty without push: IR held, Valid drops
        cyc(0, 1, 0, '0);
        chk("ldempty_valid", valid, 32'h0);
        chk("ldempty_ir",    dOut,  32'h40000010);

        // Fill past DEPTH
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, words[i]);
            if (i == 3) begin
                chk("fill_full4", full,     32'h1);
                chk("fill_ovf4",  overflow, 32'h0);
            end
        end
        chk("ovf_set",   overflow, 32'h1);
        chk("ovf_count", count,    32'd4);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, '0);
            chk($sformatf("drain_%0d", i), dOut, words[i]);
        end
        chk("drain_empty", empty, 32'h1);
        chk("drain_full",  full,  32'h0);

        // Flush with concurrent push and load
        cyc(1, 0, 0, 32'hA0000001);
        cyc(1, 0, 0, 32'hA0000002);
        cyc(1, 0, 0, 32'hA0000003);
        chk("pre_flush_count", count, 32'd3);
        cyc(1, 1, 1, 32'hAAAA0000);
        chk("flush_count", count,    32'd1);
        chk("flush_ir",    dOut,     32'h44444444);
        chk("flush_ovf",   overflow, 32'h1);
        cyc(0, 1, 0, '0);
        chk("post_flush_ir",    dOut,  32'hAAAA0000);
        chk("post_flush_empty", empty, 32'h1);

        // Push+load on nonempty queue keeps count
        cyc(1, 0, 0, 32'hB0000001);
        cyc(1, 1, 0, 32'hB0000002);
        chk("pl_ir",    dOut,  32'hB0000001);
        chk("pl_count", count, 32'd1);
        cyc(0, 1, 0, '0);
        chk("pl_ir2",   dOut,  32'hB0000002);

        // Mid-cycle asynchronous reset with Count=2, Valid=1
        cyc(1, 0, 0, 32'hC0000001);
        cyc(1, 0, 0, 32'hC0000002);
        cyc(1, 1, 0, 32'hC0000003);
        chk("prerst_count", count, 32'd2);
        chk("prerst_valid", valid, 32'h1);
        #2 rst = 1'b1;
        #1;
        chkReset("arst");
        @(posedge clk); #2 rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish, expected finish before 20000");
        $fatal(1);
    end

endmodule
